// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU slice.
//   ALU_WIDTH - default operand/result width
//   alu_op_e  - 5-bit ALU_control opcode encodings
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'b00000,
    ALU_SUB  = 5'b00010,
    ALU_SLL  = 5'b00100,
    ALU_SLT  = 5'b01000,
    ALU_BLTU = 5'b01100,
    ALU_XOR  = 5'b10000,
    ALU_SRL  = 5'b10100,
    ALU_SRA  = 5'b10110,
    ALU_OR   = 5'b11000,
    ALU_BGE  = 5'b11010,
    ALU_AND  = 5'b11100,
    ALU_BGEU = 5'b11110,
    ALU_ADD2 = 5'b11111   // address-generation add
  } alu_op_e;

endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: combinational shift unit for the ALU.
//   i_a     - value to shift
//   i_shamt - shift amount (low bits of operand B only)
//   o_sll   - logical left shift
//   o_srl   - logical right shift
//   o_sra   - arithmetic right shift (sign-filling)
module alu_shifter #(
  parameter int unsigned tamanyo = 32,
  parameter int unsigned SHW     = $clog2(tamanyo)
) (
  input  logic [tamanyo-1:0] i_a,
  input  logic [SHW-1:0]     i_shamt,
  output logic [tamanyo-1:0] o_sll,
  output logic [tamanyo-1:0] o_srl,
  output logic [tamanyo-1:0] o_sra
);

  always_comb begin
    o_sll = i_a << i_shamt;
    o_srl = i_a >> i_shamt;
    o_sra = $signed(i_a) >>> i_shamt;
  end

endmodule

// File: rtl/alu.sv
// alu: single-cycle ALU with registered result and zero flag.
//   CLK         - clock, rising edge active
//   RSTa        - asynchronous active-high reset (result 0, zero 1)
//   ALU_control - 5-bit operation select (see alu_pkg::alu_op_e)
//   A, B        - operands
//   ALU_result  - registered result, one cycle after inputs
//   zero        - registered flag, 1 when ALU_result is 0
module alu
  import alu_pkg::*;
#(
  parameter int unsigned tamanyo = ALU_WIDTH
) (
  input  logic               CLK,
  input  logic               RSTa,
  input  logic [4:0]         ALU_control,
  input  logic [tamanyo-1:0] A,
  input  logic [tamanyo-1:0] B,
  output logic [tamanyo-1:0] ALU_result,
  output logic               zero
);

  localparam int unsigned SHW = $clog2(tamanyo);

  logic [tamanyo-1:0] w_sll;
  logic [tamanyo-1:0] w_srl;
  logic [tamanyo-1:0] w_sra;
  logic [tamanyo-1:0] w_result;
  logic               w_lt_s;
  logic               w_lt_u;
  logic [tamanyo-1:0] r_result;
  logic               r_zero;

  alu_shifter #(
    .tamanyo (tamanyo),
    .SHW     (SHW)
  ) u_shifter (
    .i_a     (A),
    .i_shamt (B[SHW-1:0]),
    .o_sll   (w_sll),
    .o_srl   (w_srl),
    .o_sra   (w_sra)
  );

  always_comb begin
    w_lt_s   = $signed(A) < $signed(B);
    w_lt_u   = A < B;
    w_result = '0;
    case (ALU_control)
      ALU_ADD, ALU_ADD2: w_result = A + B;
      ALU_SUB:           w_result = A - B;
      ALU_SLL:           w_result = w_sll;
      ALU_SLT:           w_result = tamanyo'(w_lt_s);
      // BLTU yields 1 when the branch is NOT taken (A >= B unsigned)
      ALU_BLTU:          w_result = tamanyo'(!w_lt_u);
      ALU_XOR:           w_result = A ^ B;
      ALU_SRL:           w_result = w_srl;
      ALU_SRA:           w_result = w_sra;
      ALU_OR:            w_result = A | B;
      // BGE/BGEU likewise yield 1 when A < B (branch not taken)
      ALU_BGE:           w_result = tamanyo'(w_lt_s);
      ALU_AND:           w_result = A & B;
      ALU_BGEU:          w_result = tamanyo'(w_lt_u);
      default:           w_result = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RSTa) begin
    if (RSTa) begin
      r_result <= '0;
      r_zero   <= 1'b1;
    end else begin
      r_result <= w_result;
      r_zero   <= (w_result == '0);
    end
  end

  assign ALU_result = r_result;
  assign zero       = r_zero;

endmodule

// File: tb/tb_alu.sv
module tb_alu;

  logic        CLK = 1'b0;
  logic        RSTa;
  logic [4:0]  ALU_control;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] ALU_result;
  logic        zero;

  always #5 CLK = ~CLK;

  alu #(.tamanyo(32)) dut (
    .CLK         (CLK),
    .RSTa        (RSTa),
    .ALU_control (ALU_control),
    .A           (A),
    .B           (B),
    .ALU_result  (ALU_result),
    .zero        (zero)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
    logic [31:0] res;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        z;
    string       name;
  } exp_t;

  exp_t sb[$];

  // Reference behaviour, written from the opcode table.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [4:0] op);
    logic [31:0] r;
    logic [4:0]  sh;
    sh = b[4:0];
    case (op)
      5'b00000, 5'b11111: r = a + b;
      5'b00010: r = a - b;
      5'b00100: r = a << sh;
      5'b01000: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'b01100: r = (a < b) ? 32'd0 : 32'd1;
      5'b10000: r = a ^ b;
      5'b10100: r = a >> sh;
      5'b10110: begin
        r = a >> sh;
        for (int i = 0; i < 32; i++)
          if (i >= 32 - int'(sh) && a[31]) r[i] = 1'b1;
      end
      5'b11000: r = a | b;
      5'b11010: r = ($signed(a) >= $signed(b)) ? 32'd0 : 32'd1;
      5'b11100: r = a & b;
      5'b11110: r = (a >= b) ? 32'd0 : 32'd1;
      default:  r = 32'd0;
    endcase
    return r;
  endfunction

  // Drives one operation at the falling edge and records what must come out.
  task automatic issue(input vec_t v, input string name);
    @(negedge CLK);
    A = v.a; B = v.b; ALU_control = v.op;
    sb.push_back('{v.res, (v.res == 32'd0), name});
  endtask

  task automatic test_reset();
    exp_t e;
    RSTa = 1'b1; A = 32'd3; B = 32'd4; ALU_control = 5'b00000;
    #1;
    n_checks++;
    if (ALU_result !== 32'd0 || zero !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_async: result=%h zero=%b, required 00000000/1", ALU_result, zero);
    end
    repeat (2) @(posedge CLK);
    #1;
    n_checks++;
    if (ALU_result !== 32'd0 || zero !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_held: result=%h zero=%b, required 00000000/1", ALU_result, zero);
    end
    @(negedge CLK);
    RSTa = 1'b0;
    sb.push_back('{32'd7, 1'b0, "first_after_reset"});
    @(posedge CLK); #1;
    e = sb.pop_front();
    n_checks++;
    if (ALU_result !== e.res || zero !== e.z) begin
      n_fail++;
      $display("FAIL %s: result=%h zero=%b, required %h/%b", e.name, ALU_result, zero, e.res, e.z);
    end
  endtask

  task automatic test_arith();
    exp_t e;
    vec_t v[5] = '{
      '{32'd3,        32'd4,    5'b00000, 32'd7},
      '{32'd10,       32'd2,    5'b00010, 32'd8},
      '{32'd2,        32'd10,   5'b00010, 32'hFFFF_FFF8},
      '{32'hFFFF_FFFF,32'd1,    5'b00000, 32'd0},
      '{32'h0000_1000,32'h24,   5'b11111, 32'h0000_1024}};
    foreach (v[i]) begin
      issue(v[i], $sformatf("arith_%0d", i));
      @(posedge CLK); #1;
      e = sb.pop_front();
      n_checks++;
      if (ALU_result !== e.res) begin
        n_fail++;
        $display("FAIL %s result: got %h, required %h", e.name, ALU_result, e.res);
      end
      n_checks++;
      if (zero !== e.z) begin
        n_fail++;
        $display("FAIL %s zero: got %b, required %b", e.name, zero, e.z);
      end
    end
  endtask

  task automatic test_compare();
    exp_t e;
    vec_t v[8] = '{
      '{32'd30,        32'd50,        5'b01000, 32'd1},
      '{32'hFFFF_FFFF, 32'd1,         5'b01000, 32'd1},
      '{32'hFFFF_FFFF, 32'd1,         5'b01100, 32'd1},
      '{32'd1,         32'hFFFF_FFFF, 5'b01100, 32'd0},
      '{32'd5,         32'd5,         5'b11010, 32'd0},
      '{32'hFFFF_FFFF, 32'd1,         5'b11010, 32'd1},
      '{32'd1,         32'hFFFF_FFFF, 5'b11110, 32'd1},
      '{32'd5,         32'd5,         5'b11110, 32'd0}};
    foreach (v[i]) begin
      issue(v[i], $sformatf("compare_%0d", i));
      @(posedge CLK); #1;
      e = sb.pop_front();
      n_checks++;
      if (ALU_result !== e.res) begin
        n_fail++;
        $display("FAIL %s result: got %h, required %h", e.name, ALU_result, e.res);
      end
      n_checks++;
      if (zero !== e.z) begin
        n_fail++;
        $display("FAIL %s zero: got %b, required %b", e.name, zero, e.z);
      end
    end
  endtask

  task automatic test_logic();
    exp_t e;
    vec_t v[3] = '{
      '{32'd25, 32'd4, 5'b11100, 32'd0},
      '{32'd25, 32'd4, 5'b11000, 32'd29},
      '{32'd25, 32'd4, 5'b10000, 32'd29}};
    foreach (v[i]) begin
      issue(v[i], $sformatf("logic_%0d", i));
      @(posedge CLK); #1;
      e = sb.pop_front();
      n_checks++;
      if (ALU_result !== e.res || zero !== e.z) begin
        n_fail++;
        $display("FAIL %s: result=%h zero=%b, required %h/%b", e.name, ALU_result, zero, e.res, e.z);
      end
    end
  endtask

  task automatic test_shift();
    exp_t e;
    vec_t v[7] = '{
      '{32'h8000_0000, 32'd4,         5'b10110, 32'hF800_0000},
      '{32'h8000_0000, 32'd4,         5'b10100, 32'h0800_0000},
      '{32'h8000_0000, 32'd33,        5'b00100, 32'h0000_0000},
      '{32'h0000_0001, 32'd33,        5'b00100, 32'h0000_0002},
      '{32'h8000_0000, 32'hFFFF_FFE4, 5'b10110, 32'hF800_0000},
      '{32'h8000_0000, 32'd31,        5'b10100, 32'h0000_0001},
      '{32'h4000_0000, 32'd30,        5'b10110, 32'h0000_0001}};
    foreach (v[i]) begin
      issue(v[i], $sformatf("shift_%0d", i));
      @(posedge CLK); #1;
      e = sb.pop_front();
      n_checks++;
      if (ALU_result !== e.res || zero !== e.z) begin
        n_fail++;
        $display("FAIL %s: result=%h zero=%b, required %h/%b", e.name, ALU_result, zero, e.res, e.z);
      end
    end
  endtask

  task automatic test_undefined();
    exp_t e;
    vec_t v[4] = '{
      '{32'd3, 32'd4, 5'b00001, 32'd0},
      '{32'd3, 32'd4, 5'b00011, 32'd0},
      '{32'd3, 32'd4, 5'b01111, 32'd0},
      '{32'd3, 32'd4, 5'b11101, 32'd0}};
    foreach (v[i]) begin
      issue(v[i], $sformatf("undef_%0d", i));
      @(posedge CLK); #1;
      e = sb.pop_front();
      n_checks++;
      if (ALU_result !== e.res || zero !== e.z) begin
        n_fail++;
        $display("FAIL %s: result=%h zero=%b, required %h/%b", e.name, ALU_result, zero, e.res, e.z);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    vec_t v;
    logic [4:0] ops[13] = '{5'b00000, 5'b00010, 5'b00100, 5'b01000, 5'b01100, 5'b10000,
                            5'b10100, 5'b10110, 5'b11000, 5'b11010, 5'b11100, 5'b11110,
                            5'b11111};
    for (int i = 0; i < 300; i++) begin
      v.a  = (i % 7 == 0) ? 32'h8000_0000 ^ $urandom_range(0, 3) : $urandom;
      v.b  = (i % 5 == 0) ? v.a : $urandom;
      v.op = (i % 4 == 3) ? 5'($urandom) : ops[$urandom_range(0, 12)];
      v.res = model(v.a, v.b, v.op);
      issue(v, $sformatf("b2b_%0d_op%b", i, v.op));
      @(posedge CLK); #1;
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL %s: scoreboard empty", "b2b");
      end else begin
        e = sb.pop_front();
        n_checks++;
        if (ALU_result !== e.res || zero !== e.z) begin
          n_fail++;
          $display("FAIL %s: result=%h zero=%b, required %h/%b", e.name, ALU_result, zero, e.res, e.z);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    vec_t v = '{32'd3, 32'd4, 5'b00000, 32'd7};
    issue(v, "pre_reset");
    @(posedge CLK); #1;
    e = sb.pop_front();
    n_checks++;
    if (ALU_result !== e.res || zero !== e.z) begin
      n_fail++;
      $display("FAIL %s: result=%h zero=%b, required %h/%b", e.name, ALU_result, zero, e.res, e.z);
    end
    #1 RSTa = 1'b1;
    #1;
    sb.delete();
    n_checks++;
    if (ALU_result !== 32'd0 || zero !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_async: result=%h zero=%b, required 00000000/1", ALU_result, zero);
    end
    RSTa = 1'b0;
    #1;
    n_checks++;
    if (ALU_result !== 32'd0 || zero !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_release: result=%h zero=%b, required 00000000/1", ALU_result, zero);
    end
    sb.push_back('{32'd7, 1'b0, "after_mid_reset"});
    @(posedge CLK); #1;
    e = sb.pop_front();
    n_checks++;
    if (ALU_result !== e.res || zero !== e.z) begin
      n_fail++;
      $display("FAIL %s: result=%h zero=%b, required %h/%b", e.name, ALU_result, zero, e.res, e.z);
    end
    v = '{32'd3, 32'd4, 5'b00001, 32'd0};
    issue(v, "undef_after_reset");
    @(posedge CLK); #1;
    e = sb.pop_front();
    n_checks++;
    if (ALU_result !== e.res || zero !== e.z) begin
      n_fail++;
      $display("FAIL %s: result=%h zero=%b, required %h/%b", e.name, ALU_result, zero, e.res, e.z);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_compare();
    test_logic();
    test_shift();
    test_undefined();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
